program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot-time loader directly upstream of the single-cycle core's instruction memory.
- Receives a byte stream over a valid/ready handshake, assembles 19-bit instructions, and writes them sequentially into instruction memory from address 0.
- Holds the core in reset (cpu_rst) until a complete, checksum-verified image has been written.
- Restarts on a reload pulse.

Parameters:
- ADDR_W, 12, instruction memory address width; memory depth = 2**ADDR_W words.
- INSTR_W, 19, instruction width in bits; must be ≤ 24.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte; transfer occurs when in_valid && in_ready at a rising edge.
- reload  input  1  one-cycle pulse; restarts loading, honoured only in DONE or ERROR.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  INSTR_W  write data.
- cpu_rst  output  1  reset to core; high except in DONE.
- done  output  1  image loaded and verified.
- error  output  1  load aborted.
- error_code  output  2  0 none, 1 count overflow, 2 format, 3 checksum.

Behaviour:
- Stream format:
  - CNT_LO, CNT_HI: 16-bit word count N, little-endian.
  - N records of 3 bytes each, little-endian; instruction = bits [INSTR_W-1:0] of the 24-bit value.
  - One checksum byte: XOR of all preceding bytes, header included.
- Reset values: state=CNT_LO, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, done=0, error=0, error_code=0, word counter=0, byte index=0, running xor=0.
- in_ready is combinational: 1 in CNT_LO, CNT_HI, DATA, CHK; 0 in DONE and ERROR; 0 while rst is high.
- States and transitions (each step advances on an accepted byte; xor updated on every accepted byte except the checksum byte):
  - CNT_LO -> CNT_HI: latch low byte of N.
  - CNT_HI: latch high byte of N, then:
    - N > 2**ADDR_W: ERROR, code 1.
    - N = 0: CHK.
    - otherwise: DATA.
  - DATA: byte index cycles 0,1,2.
    - On byte 2, check format: bits [23:INSTR_W] of the assembled value must be zero; if not, ERROR, code 2, no write.
    - Otherwise, next cycle: imem_we=1, imem_wdata=value, imem_addr=word counter. The word counter then increments.
    - After the Nth word's byte 2: CHK.
  - CHK: compare byte with running xor.
    - Equal: DONE.
    - Otherwise: ERROR, code 3.
  - DONE: done=1, cpu_rst=0. Remains until reload or rst.
  - ERROR: error=1, cpu_rst=1, error_code held. Remains until reload or rst.
- Write timing: all memory outputs are registered. imem_we pulses exactly one cycle, in the cycle after byte 2 is accepted. imem_addr/imem_wdata are held stable until the next write.
- Back-to-back bytes (in_valid constantly high) are accepted every cycle with no stalls. Gaps in in_valid are tolerated anywhere and preserve state.
- Word counter wraps correctly: N = 2**ADDR_W writes addresses 0 .. 2**ADDR_W-1 with no overflow error.
- reload in DONE/ERROR: next cycle is CNT_LO; counters, xor, done, error and error_code are cleared; cpu_rst returns high in that same cycle.
- reload in any other state is ignored.
- rst mid-load: returns to reset values on the next edge; partially written memory is not cleared.
- rst has priority over reload; reload has priority over an in_valid in the same cycle.

Test Plan:
- Basic load: N=2, words 0x12345 and 0x7FFFF, correct checksum, bytes back-to-back -> imem writes at addr 0 = 0x12345 and addr 1 = 0x7FFFF on consecutive write pulses; done=1, cpu_rst=0 one cycle after checksum accepted.
- Empty image: N=0, checksum 0x00 -> DONE with no imem_we pulse. Same stream with checksum 0x01 -> error=1, error_code=3, cpu_rst=1.
- Format error: N=1, bytes 0x00,0x00,0x08 (bit 19 set) -> no write, error_code=2, in_ready=0.
- Overflow: ADDR_W=12, header N=0x1001 -> error_code=1 immediately after CNT_HI. Header N=0x1000 with full data -> last write at addr 0xFFF, DONE.
- Handshake gaps: N=1 with in_valid toggling every other cycle -> identical write and DONE; no byte lost or duplicated.
- Reload/reset: after DONE, pulse reload and load a different N=1 image -> cpu_rst high during reload, new word at addr 0, DONE again. Assert rst after the second data byte -> reset values next cycle, no write pulse.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: boot loader assembling a checksummed byte stream into instruction memory words
module program_loader #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               reload,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_rst,
  output logic               done,
  output logic               error,
  output logic [1:0]         error_code
);
  typedef enum logic [2:0] {CNT_LO, CNT_HI, DATA, CHK, DONE, ERR} state_t;
  localparam logic [16:0] MAX_N = 17'(2 ** ADDR_W);
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d, wcnt_q, wcnt_d, buf_q, buf_d;
  logic [7:0] xor_q, xor_d;
  logic [1:0] bidx_q, bidx_d, code_q, code_d;
  logic we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic acc;
  logic [23:0] word;
  assign in_ready = !rst && (state_q inside {CNT_LO, CNT_HI, DATA, CHK});
  assign acc = in_valid && in_ready;
  assign word = {in_data, buf_q};
  assign imem_we = we_q;
  assign imem_addr = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst = state_q != DONE;
  assign done = state_q == DONE;
  assign error = state_q == ERR;
  assign error_code = code_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wcnt_d = wcnt_q;
    buf_d = buf_q;
    xor_d = xor_q;
    bidx_d = bidx_q;
    code_d = code_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      CNT_LO: if (acc) begin
        cnt_d[7:0] = in_data;
        xor_d = xor_q ^ in_data;
        state_d = CNT_HI;
      end
      CNT_HI: if (acc) begin
        cnt_d[15:8] = in_data;
        xor_d = xor_q ^ in_data;
        state_d = {1'b0, in_data, cnt_q[7:0]} > MAX_N ? ERR : ({in_data, cnt_q[7:0]} == 16'd0 ? CHK : DATA);
        code_d = {1'b0, in_data, cnt_q[7:0]} > MAX_N ? 2'd1 : code_q;
      end
      DATA: if (acc) begin
        xor_d = xor_q ^ in_data;
        bidx_d = bidx_q == 2'd2 ? 2'd0 : bidx_q + 2'd1;
        if (bidx_q == 2'd0) buf_d[7:0] = in_data;
        if (bidx_q == 2'd1) buf_d[15:8] = in_data;
        if (bidx_q == 2'd2) begin
          if ((word >> INSTR_W) != 24'd0) begin
            state_d = ERR;
            code_d = 2'd2;
          end else begin
            we_d = 1'b1;
            addr_d = wcnt_q[ADDR_W-1:0];
            wdata_d = word[INSTR_W-1:0];
            wcnt_d = wcnt_q + 16'd1;
            state_d = wcnt_q + 16'd1 == cnt_q ? CHK : DATA;
          end
        end
      end
      CHK: if (acc) begin
        state_d = in_data == xor_q ? DONE : ERR;
        code_d = in_data == xor_q ? code_q : 2'd3;
      end
      default: if (reload) begin
        state_d = CNT_LO;
        cnt_d = '0;
        wcnt_d = '0;
        xor_d = '0;
        bidx_d = '0;
        code_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CNT_LO;
      cnt_q <= '0;
      wcnt_q <= '0;
      buf_q <= '0;
      xor_q <= '0;
      bidx_q <= '0;
      code_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wcnt_q <= wcnt_d;
      buf_q <= buf_d;
      xor_q <= xor_d;
      bidx_q <= bidx_d;
      code_q <= code_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader
module tb_program_loader;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, reload = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, imem_we, cpu_rst, done, error;
  logic [11:0] imem_addr;
  logic [18:0] imem_wdata;
  logic [1:0] error_code;
  logic [18:0] mem [0:4095];
  logic [7:0] x;
  int checks = 0, errors = 0, wr_n = 0;
  always #5 clk = ~clk;
  program_loader #(.ADDR_W(12), .INSTR_W(19)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error), .error_code(error_code)
  );
  always @(posedge clk) if (imem_we) begin
    mem[imem_addr] <= imem_wdata;
    wr_n <= wr_n + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    in_data = b;
    in_valid = 1'b1;
    x ^= b;
    t = 0;
    while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (t == 20) chk("ready_timeout", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic start(input logic [15:0] n, input int gap);
    x = 8'h00;
    send(n[7:0], gap);
    send(n[15:8], gap);
  endtask
  task automatic word(input logic [23:0] w, input int gap);
    send(w[7:0], gap);
    send(w[15:8], gap);
    send(w[23:16], gap);
  endtask
  task automatic fin(input logic good, input int gap);
    send(good ? x : x ^ 8'h01, gap);
  endtask
  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_code", error_code, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    rst = 1'b0;
    #1;
    chk("idle_ready", in_ready, 1);
    start(16'd2, 0);
    word(24'h012345, 0);
    chk("b_we0", imem_we, 1);
    chk("b_addr0", imem_addr, 0);
    chk("b_wdata0", imem_wdata, 19'h12345);
    word(24'h07FFFF, 0);
    chk("b_we1", imem_we, 1);
    chk("b_addr1", imem_addr, 1);
    fin(1, 0);
    chk("b_done", done, 1);
    chk("b_cpu_rst", cpu_rst, 0);
    chk("b_ready", in_ready, 0);
    chk("b_we_off", imem_we, 0);
    chk("b_wdata_held", imem_wdata, 19'h7FFFF);
    chk("b_wr_n", wr_n, 2);
    chk("b_mem0", mem[0], 19'h12345);
    chk("b_mem1", mem[1], 19'h7FFFF);
    pulse_reload();
    chk("rl_cpu_rst", cpu_rst, 1);
    chk("rl_done", done, 0);
    chk("rl_ready", in_ready, 1);
    start(16'd0, 0);
    fin(1, 0);
    chk("e_done", done, 1);
    chk("e_wr_n", wr_n, 2);
    pulse_reload();
    start(16'd0, 0);
    fin(0, 0);
    chk("c_error", error, 1);
    chk("c_code", error_code, 3);
    chk("c_cpu_rst", cpu_rst, 1);
    chk("c_done", done, 0);
    pulse_reload();
    chk("f_clr_error", error, 0);
    chk("f_clr_code", error_code, 0);
    start(16'd1, 0);
    word(24'h080000, 0);
    chk("f_error", error, 1);
    chk("f_code", error_code, 2);
    chk("f_ready", in_ready, 0);
    chk("f_we", imem_we, 0);
    @(posedge clk); #1;
    chk("f_wr_n", wr_n, 2);
    pulse_reload();
    start(16'h1001, 0);
    chk("o_error", error, 1);
    chk("o_code", error_code, 1);
    pulse_reload();
    start(16'h1000, 0);
    for (int i = 0; i < 4096; i++) word(24'(i), 0);
    fin(1, 0);
    chk("o_done", done, 1);
    chk("o_error_clr", error, 0);
    chk("o_wr_n", wr_n, 4098);
    chk("o_last_addr", imem_addr, 12'hFFF);
    chk("o_mem0", mem[0], 0);
    chk("o_mem800", mem[12'h800], 19'h800);
    chk("o_memfff", mem[12'hFFF], 19'hFFF);
    pulse_reload();
    start(16'd1, 1);
    send(8'hC3, 1);
    pulse_reload();
    send(8'hA5, 1);
    send(8'h02, 1);
    fin(1, 1);
    chk("g_done", done, 1);
    chk("g_wr_n", wr_n, 4099);
    chk("g_mem0", mem[0], 19'h2A5C3);
    pulse_reload();
    chk("r_cpu_rst", cpu_rst, 1);
    start(16'd1, 0);
    word(24'h000ABC, 0);
    fin(1, 0);
    chk("r_done", done, 1);
    chk("r_mem0", mem[0], 19'h00ABC);
    chk("r_wr_n", wr_n, 4100);
    pulse_reload();
    start(16'd1, 0);
    send(8'hBC, 0);
    send(8'h0A, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("m_ready", in_ready, 0);
    chk("m_cpu_rst", cpu_rst, 1);
    chk("m_we", imem_we, 0);
    chk("m_addr", imem_addr, 0);
    chk("m_wdata", imem_wdata, 0);
    chk("m_error", error, 0);
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("m_wr_n", wr_n, 4100);
    chk("m_ready_after", in_ready, 1);
    start(16'd1, 0);
    word(24'h000001, 0);
    chk("p_we", imem_we, 1);
    chk("p_addr", imem_addr, 0);
    chk("p_wdata", imem_wdata, 1);
    fin(1, 0);
    chk("p_done", done, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
